secure_boot_seq: RTL and testbench



---
 rtl/secboot_pkg.sv | 37 +++
 rtl/secboot_lane_digest.sv | 47 ++++
 rtl/secure_boot_seq.sv | 243 ++++++++++++++++++++++++
 tb/tb_secure_boot_seq.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/secboot_pkg.sv
// -----------------------------------------------------------------------------
// secboot_pkg
// Shared definitions for the secure boot sequencer:
//   - boot_state_t : FSM state enum with fixed encodings (visible on boot_stage)
//   - FAIL_*       : fail_code values
//   - rotl1()      : rotate-left-by-one over a run-time width, used by the
//                    lane digest so the package stays width-agnostic
// -----------------------------------------------------------------------------
package secboot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_CHECK = 3'd2,
    ST_NEXT  = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd7
  } boot_state_t;

  localparam logic [1:0] FAIL_NONE     = 2'd0;
  localparam logic [1:0] FAIL_DIGEST   = 2'd1;
  localparam logic [1:0] FAIL_ROLLBACK = 2'd2;
  localparam logic [1:0] FAIL_TIMEOUT  = 2'd3;

  // Widest word rotl1 can handle; callers zero-extend into this width.
  localparam int unsigned ROT_MAX_W = 64;

  // Rotate the low w bits of x left by one; bits at and above w return 0.
  function automatic logic [ROT_MAX_W-1:0] rotl1(input logic [ROT_MAX_W-1:0] x,
                                                  input int unsigned          w);
    logic [ROT_MAX_W-1:0] r;
    r = (x << 1) | ((x >> (w - 1)) & ROT_MAX_W'(1));
    if (w < ROT_MAX_W) r = r & ((ROT_MAX_W'(1) << w) - ROT_MAX_W'(1));
    return r;
  endfunction

endpackage

// File: rtl/secboot_lane_digest.sv
// -----------------------------------------------------------------------------
// secboot_lane_digest
// LANES parallel rotate-and-add accumulators. Each accepted word updates one
// lane: lane[word_idx] <= rotl1(lane[word_idx]) + word (mod 2^DATA_W).
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   clear       : zero all lanes (start of an image attempt)
//   word_valid  : word is accepted this cycle
//   word_idx    : target lane (word index modulo LANES)
//   word        : flash data word
//   digest      : all lanes, lane 0 in the LSBs
// -----------------------------------------------------------------------------
module secboot_lane_digest
  import secboot_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int LANES  = 8,
  localparam int IDX_W  = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    word_valid,
  input  logic [IDX_W-1:0]        word_idx,
  input  logic [DATA_W-1:0]       word,
  output logic [LANES*DATA_W-1:0] digest
);

  logic [DATA_W-1:0] lane_q [LANES];

  // NOTE: the lane array is a small register file, not a RAM, so it is reset
  // like any other flop; a defined zero digest after rst is observable state.
  // NOTE: sequential state is written only with <= so every lane samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int k = 0; k < LANES; k++) lane_q[k] <= '0;
    end else if (word_valid) begin
      lane_q[word_idx] <= DATA_W'(rotl1(ROT_MAX_W'(lane_q[word_idx]), DATA_W)) + word;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_digest
    assign digest[k*DATA_W +: DATA_W] = lane_q[k];
  end

endmodule

// File: rtl/secure_boot_seq.sv
// -----------------------------------------------------------------------------
// secure_boot_seq
// Fetches NUM_IMG images of IMG_WORDS words from flash, folds each into a
// LANES-wide digest and compares it against the golden value. Mismatches are
// retried up to MAX_RETRY times; a stalled flash raises a timeout.
// Build option: SECBOOT_ANTI_ROLLBACK_EN enables the version (word 0) check
// against min_version and the new_min_version write-back.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   start              : pulse, begins the sequence from IDLE
//   flash_req/addr     : read request (held until accepted) and byte address
//   flash_rdata/rvalid : read data; a word is taken when req && rvalid
//   exp_digest         : golden digests, image 0 / lane 0 in the LSBs
//   min_version        : fused minimum version per image
//   new_min_version    : version to program back into the fuses
//   img_verified       : per-image pass flags
//   boot_stage         : current FSM state encoding
//   busy, boot_ready   : in progress / all images verified
//   security_violation : sequence failed; cause in fail_code, image in fail_img
// -----------------------------------------------------------------------------
module secure_boot_seq
  import secboot_pkg::*;
#(
  parameter  int          DATA_W      = 32,
  parameter  int          NUM_IMG     = 2,
  parameter  int          IMG_WORDS   = 256,
  parameter  int          LANES       = 8,
  parameter  logic [31:0] IMG_BASE    = 32'h1000_0000,
  parameter  logic [31:0] IMG_STRIDE  = 32'h0000_1000,
  parameter  int          MAX_RETRY   = 2,
  parameter  int          TIMEOUT_CYC = 1024,
  localparam int          IMG_W       = (NUM_IMG > 1) ? $clog2(NUM_IMG) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  output logic                            flash_req,
  output logic [31:0]                     flash_addr,
  input  logic [DATA_W-1:0]               flash_rdata,
  input  logic                            flash_rvalid,
  input  logic [NUM_IMG*LANES*DATA_W-1:0] exp_digest,
  input  logic [NUM_IMG*DATA_W-1:0]       min_version,
  output logic [NUM_IMG*DATA_W-1:0]       new_min_version,
  output logic [NUM_IMG-1:0]              img_verified,
  output logic [2:0]                      boot_stage,
  output logic                            busy,
  output logic                            boot_ready,
  output logic                            security_violation,
  output logic [1:0]                      fail_code,
  output logic [IMG_W-1:0]                fail_img
);

  localparam int WORD_W  = (IMG_WORDS > 1) ? $clog2(IMG_WORDS) : 1;
  localparam int LANE_W  = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int TO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam int DIG_W   = LANES * DATA_W;

  boot_state_t        state;
  logic [WORD_W-1:0]  word_q;
  logic [IMG_W-1:0]   img_q;
  logic [RETRY_W-1:0] retry_q;
  logic [TO_W-1:0]    to_q;

  logic               accept;
  logic               lane_clear;
  logic [LANE_W-1:0]  lane_idx;
  logic [DIG_W-1:0]   digest;
  logic [DIG_W-1:0]   img_golden;
  logic               digest_match;
  logic               last_word;
  logic               last_img;

  function automatic logic [31:0] addr_of(input logic [IMG_W-1:0]  i,
                                          input logic [WORD_W-1:0] w);
    return IMG_BASE + 32'(i) * IMG_STRIDE + 32'(w) * 32'(DATA_W / 8);
  endfunction

  // flash_req is only ever high in FETCH; gating on it drops stray rvalid.
  assign accept       = (state == ST_FETCH) && flash_req && flash_rvalid;
  // Lanes are zero whenever a new attempt can begin: IDLE, and the cycle
  // leaving CHECK/NEXT. CHECK still reads the old value before the edge.
  assign lane_clear   = (state == ST_IDLE) || (state == ST_CHECK) || (state == ST_NEXT);
  assign lane_idx     = (LANES > 1) ? word_q[LANE_W-1:0] : '0;
  assign img_golden   = exp_digest[int'(img_q)*DIG_W +: DIG_W];
  assign digest_match = (digest == img_golden);
  assign last_word    = (word_q == WORD_W'(IMG_WORDS - 1));
  assign last_img     = (img_q == IMG_W'(NUM_IMG - 1));
  assign boot_stage   = state;

  secboot_lane_digest #(
    .DATA_W (DATA_W),
    .LANES  (LANES)
  ) u_digest (
    .clk        (clk),
    .rst        (rst),
    .clear      (lane_clear),
    .word_valid (accept),
    .word_idx   (lane_idx),
    .word       (flash_rdata),
    .digest     (digest)
  );

`ifdef SECBOOT_ANTI_ROLLBACK_EN
  // Version word is only consumed by the rollback check.
  logic [DATA_W-1:0]         version_q;
  logic [NUM_IMG*DATA_W-1:0] new_min_q;
  logic [DATA_W-1:0]         cur_min;

  assign cur_min         = min_version[int'(img_q)*DATA_W +: DATA_W];
  assign new_min_version = new_min_q;
`else
  assign new_min_version = min_version;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= ST_IDLE;
      word_q             <= '0;
      img_q              <= '0;
      retry_q            <= '0;
      to_q               <= '0;
      flash_req          <= 1'b0;
      flash_addr         <= '0;
      img_verified       <= '0;
      busy               <= 1'b0;
      boot_ready         <= 1'b0;
      security_violation <= 1'b0;
      fail_code          <= FAIL_NONE;
      fail_img           <= '0;
`ifdef SECBOOT_ANTI_ROLLBACK_EN
      version_q          <= '0;
      new_min_q          <= min_version;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_FETCH;
            busy       <= 1'b1;
            word_q     <= '0;
            img_q      <= '0;
            retry_q    <= '0;
            to_q       <= '0;
            flash_req  <= 1'b1;
            flash_addr <= addr_of('0, '0);
          end
        end

        ST_FETCH: begin
          if (accept) begin
            to_q <= '0;
`ifdef SECBOOT_ANTI_ROLLBACK_EN
            if (word_q == '0) version_q <= flash_rdata;
`endif
            if (last_word) begin
              flash_req <= 1'b0;
              state     <= ST_CHECK;
            end else begin
              word_q     <= word_q + 1'b1;
              flash_addr <= addr_of(img_q, word_q + 1'b1);
            end
          end else if (to_q == TO_W'(TIMEOUT_CYC - 1)) begin
            state              <= ST_ERROR;
            flash_req          <= 1'b0;
            busy               <= 1'b0;
            security_violation <= 1'b1;
            img_verified       <= '0;
            fail_code          <= FAIL_TIMEOUT;
            fail_img           <= img_q;
          end else begin
            to_q <= to_q + 1'b1;
          end
        end

        ST_CHECK: begin
`ifdef SECBOOT_ANTI_ROLLBACK_EN
          // A rolled-back image fails outright, whatever its digest.
          if (version_q < cur_min) begin
            state              <= ST_ERROR;
            busy               <= 1'b0;
            security_violation <= 1'b1;
            img_verified       <= '0;
            fail_code          <= FAIL_ROLLBACK;
            fail_img           <= img_q;
          end else
`endif
          if (digest_match) begin
            img_verified[img_q] <= 1'b1;
`ifdef SECBOOT_ANTI_ROLLBACK_EN
            new_min_q[int'(img_q)*DATA_W +: DATA_W] <= (version_q > cur_min) ? version_q : cur_min;
`endif
            state <= ST_NEXT;
          end else if (retry_q < RETRY_W'(MAX_RETRY)) begin
            retry_q    <= retry_q + 1'b1;
            word_q     <= '0;
            to_q       <= '0;
            flash_req  <= 1'b1;
            flash_addr <= addr_of(img_q, '0);
            state      <= ST_FETCH;
          end else begin
            state              <= ST_ERROR;
            busy               <= 1'b0;
            security_violation <= 1'b1;
            img_verified       <= '0;
            fail_code          <= FAIL_DIGEST;
            fail_img           <= img_q;
          end
        end

        ST_NEXT: begin
          if (last_img) begin
            state      <= ST_DONE;
            busy       <= 1'b0;
            boot_ready <= 1'b1;
          end else begin
            img_q      <= img_q + 1'b1;
            retry_q    <= '0;
            word_q     <= '0;
            to_q       <= '0;
            flash_req  <= 1'b1;
            flash_addr <= addr_of(img_q + 1'b1, '0);
            state      <= ST_FETCH;
          end
        end

        // DONE and ERROR are terminal until rst; start is ignored.
        ST_DONE, ST_ERROR: ;

        // Unused encodings fail closed.
        default: begin
          state              <= ST_ERROR;
          flash_req          <= 1'b0;
          busy               <= 1'b0;
          boot_ready         <= 1'b0;
          security_violation <= 1'b1;
          img_verified       <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_secure_boot_seq.sv
// -----------------------------------------------------------------------------
// tb_secure_boot_seq
// Scoreboard bench for secure_boot_seq (DATA_W=32, NUM_IMG=2, IMG_WORDS=16,
// LANES=8). Stimulus pushes expected flash addresses and expected terminal
// status into queues; a negedge monitor pops and compares whenever a word is
// accepted or the DUT reaches DONE/ERROR. With every flash word = 1, each lane
// sees two words: rotl1(rotl1(0)+1)+1 = 3, so the good golden lane is 3.
// -----------------------------------------------------------------------------
module tb_secure_boot_seq;

  localparam int DATA_W    = 32;
  localparam int NUM_IMG   = 2;
  localparam int IMG_WORDS = 16;
  localparam int LANES     = 8;

  typedef enum {FM_HIGH, FM_LOW, FM_WAIT, FM_STRAY} flash_mode_t;

  typedef struct {
    logic [2:0] stage;
    logic [1:0] verified;
    logic       ready;
    logic       viol;
    logic [1:0] code;
    logic       fimg;
  } result_t;

  logic                            clk = 1'b0;
  logic                            rst = 1'b1;
  logic                            start = 1'b0;
  logic                            flash_req;
  logic [31:0]                     flash_addr;
  logic [DATA_W-1:0]               flash_rdata = 32'h0000_0001;
  logic                            flash_rvalid = 1'b0;
  logic [NUM_IMG*LANES*DATA_W-1:0] exp_digest = '0;
  logic [NUM_IMG*DATA_W-1:0]       min_version = {32'd1, 32'd1};
  logic [NUM_IMG*DATA_W-1:0]       new_min_version;
  logic [NUM_IMG-1:0]              img_verified;
  logic [2:0]                      boot_stage;
  logic                            busy;
  logic                            boot_ready;
  logic                            security_violation;
  logic [1:0]                      fail_code;
  logic                            fail_img;

  int          vectors = 0;
  int          miscompares = 0;
  int          acc_cnt = 0;
  int          req_cycles = 0;
  int          done_cnt = 0;
  flash_mode_t mode = FM_LOW;
  int          wait_left = 0;

  logic [31:0] exp_addr_q [$];
  result_t     exp_res_q  [$];

  secure_boot_seq #(
    .DATA_W      (DATA_W),
    .NUM_IMG     (NUM_IMG),
    .IMG_WORDS   (IMG_WORDS),
    .LANES       (LANES),
    .IMG_BASE    (32'h1000_0000),
    .IMG_STRIDE  (32'h0000_1000),
    .MAX_RETRY   (2),
    .TIMEOUT_CYC (1024)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .start              (start),
    .flash_req          (flash_req),
    .flash_addr         (flash_addr),
    .flash_rdata        (flash_rdata),
    .flash_rvalid       (flash_rvalid),
    .exp_digest         (exp_digest),
    .min_version        (min_version),
    .new_min_version    (new_min_version),
    .img_verified       (img_verified),
    .boot_stage         (boot_stage),
    .busy               (busy),
    .boot_ready         (boot_ready),
    .security_violation (security_violation),
    .fail_code          (fail_code),
    .fail_img           (fail_img)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic report_fail(input string name, input logic [63:0] act);
    vectors++;
    miscompares++;
    $display("FAIL %s: got 0x%0h with no expectation pending", name, act);
  endtask

  // Flash model: drives rvalid for the coming edge, 1 ns after each edge.
  always begin
    @(posedge clk);
    #1;
    case (mode)
      FM_HIGH:  flash_rvalid = 1'b1;
      FM_LOW:   flash_rvalid = 1'b0;
      FM_STRAY: flash_rvalid = ~flash_rvalid;
      FM_WAIT: begin
        if (!flash_req) begin
          flash_rvalid = 1'b0;
        end else if (wait_left == 0) begin
          flash_rvalid = 1'b1;
          wait_left    = $urandom_range(0, 3);
        end else begin
          flash_rvalid = 1'b0;
          wait_left--;
        end
      end
      default: flash_rvalid = 1'b0;
    endcase
  end

  // Monitor: compares every accepted address and every terminal status.
  logic [31:0] mon_addr;
  result_t     mon_res;
  logic        term_prev = 1'b0;
  logic        term;

  always @(negedge clk) begin
    if (!rst && flash_req) req_cycles++;
    if (!rst && flash_req && flash_rvalid) begin
      acc_cnt++;
      if (exp_addr_q.size() == 0) begin
        report_fail("addr_extra", 64'(flash_addr));
      end else begin
        mon_addr = exp_addr_q.pop_front();
        check("flash_addr", 64'(flash_addr), 64'(mon_addr));
      end
    end
    term = boot_ready || security_violation;
    if (term && !term_prev) begin
      done_cnt++;
      if (exp_res_q.size() == 0) begin
        report_fail("result_extra", 64'(boot_stage));
      end else begin
        mon_res = exp_res_q.pop_front();
        check("res_stage",    64'(boot_stage),         64'(mon_res.stage));
        check("res_verified", 64'(img_verified),       64'(mon_res.verified));
        check("res_ready",    64'(boot_ready),         64'(mon_res.ready));
        check("res_viol",     64'(security_violation), 64'(mon_res.viol));
        check("res_code",     64'(fail_code),          64'(mon_res.code));
        check("res_fimg",     64'(fail_img),           64'(mon_res.fimg));
        check("res_busy",     64'(busy),               64'd0);
        check("res_req",      64'(flash_req),          64'd0);
      end
    end
    term_prev = term;
  end

  task automatic push_image_addrs(input int img);
    for (int w = 0; w < IMG_WORDS; w++)
      exp_addr_q.push_back(32'h1000_0000 + 32'(img) * 32'h1000 + 32'(w) * 32'd4);
  endtask

  task automatic push_result(input logic [2:0] stage, input logic [1:0] ver, input logic ready,
                             input logic viol, input logic [1:0] code, input logic fimg);
    result_t r;
    r.stage = stage; r.verified = ver; r.ready = ready;
    r.viol = viol; r.code = code; r.fimg = fimg;
    exp_res_q.push_back(r);
  endtask

  task automatic set_golden(input logic [31:0] g0, input logic [31:0] g1);
    for (int l = 0; l < LANES; l++) begin
      exp_digest[l*DATA_W +: DATA_W]               = g0;
      exp_digest[(LANES + l)*DATA_W +: DATA_W]     = g1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int base = done_cnt;
    int n = 0;
    while (done_cnt == base && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (done_cnt == base) report_fail({name, "_no_terminal"}, 64'(boot_stage));
  endtask

  task automatic run_good_boot(input string name);
    push_image_addrs(0);
    push_image_addrs(1);
    push_result(3'd4, 2'b11, 1'b1, 1'b0, 2'd0, 1'b0);
    pulse_start();
    check({name, "_stage_fetch"}, 64'(boot_stage), 64'd1);
    check({name, "_busy"},        64'(busy),       64'd1);
    wait_done(name);
    check({name, "_addr_q_empty"}, 64'(exp_addr_q.size()), 64'd0);
  endtask

  logic [NUM_IMG*DATA_W-1:0] exp_new_min;
  int base_acc;
  int base_req;
  int n;

  initial begin
    set_golden(32'h3, 32'h3);
`ifdef SECBOOT_ANTI_ROLLBACK_EN
    min_version = {32'd0, 32'd1};
`endif
    // Reset state, sampled while rst is still held.
    repeat (3) @(posedge clk);
    #1;
    check("rst_stage",   64'(boot_stage),         64'd0);
    check("rst_req",     64'(flash_req),          64'd0);
    check("rst_addr",    64'(flash_addr),         64'd0);
    check("rst_busy",    64'(busy),               64'd0);
    check("rst_ready",   64'(boot_ready),         64'd0);
    check("rst_viol",    64'(security_violation), 64'd0);
    check("rst_code",    64'(fail_code),          64'd0);
    check("rst_fimg",    64'(fail_img),           64'd0);
    check("rst_verif",   64'(img_verified),       64'd0);
    check("rst_new_min", 64'(new_min_version),    64'(min_version));
    rst = 1'b0;

    // Stray rvalid in IDLE: no request, no lane change.
    mode = FM_STRAY;
    repeat (10) @(posedge clk);
    #1;
    check("stray_lanes", 64'(|dut.u_digest.digest), 64'd0);
    check("stray_req",   64'(flash_req),            64'd0);
    check("stray_stage", 64'(boot_stage),           64'd0);

    // Nominal boot, flash_rvalid tied high.
    mode = FM_HIGH;
    run_good_boot("good");
`ifdef SECBOOT_ANTI_ROLLBACK_EN
    exp_new_min = {32'd1, 32'd1};
`else
    exp_new_min = min_version;
`endif
    check("good_new_min", 64'(new_min_version), 64'(exp_new_min));

    // start in DONE is ignored.
    pulse_start();
    repeat (3) @(posedge clk);
    #1;
    check("done_lock_stage", 64'(boot_stage), 64'd4);
    check("done_lock_ready", 64'(boot_ready), 64'd1);
    check("done_lock_req",   64'(flash_req),  64'd0);

    // rst after word 5 of image 0, then a fresh complete boot.
    do_reset();
    base_acc = acc_cnt;
    for (int w = 0; w < 6; w++) exp_addr_q.push_back(32'h1000_0000 + 32'(w) * 32'd4);
    pulse_start();
    n = 0;
    while (acc_cnt - base_acc < 6 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("abort_stage",      64'(boot_stage),        64'd0);
    check("abort_req",        64'(flash_req),         64'd0);
    check("abort_addr_empty", 64'(exp_addr_q.size()), 64'd0);
    run_good_boot("rerun");

    // Random 0-3 wait states per word.
    do_reset();
    mode = FM_WAIT;
    run_good_boot("wait");

    // Image 1 golden wrong: fetched three times, then digest failure.
    do_reset();
    mode = FM_HIGH;
    set_golden(32'h3, 32'h4);
    push_image_addrs(0);
    for (int a = 0; a < 3; a++) push_image_addrs(1);
    push_result(3'd7, 2'b00, 1'b0, 1'b1, 2'd1, 1'b1);
    pulse_start();
    wait_done("retry");
    check("retry_addr_q_empty", 64'(exp_addr_q.size()), 64'd0);

    // start in ERROR is ignored.
    pulse_start();
    repeat (3) @(posedge clk);
    #1;
    check("err_lock_stage", 64'(boot_stage),         64'd7);
    check("err_lock_viol",  64'(security_violation), 64'd1);
    check("err_lock_req",   64'(flash_req),          64'd0);

    // Flash never answers: timeout after 1024 request cycles.
    do_reset();
    set_golden(32'h3, 32'h3);
    mode = FM_LOW;
    base_req = req_cycles;
    push_result(3'd7, 2'b00, 1'b0, 1'b1, 2'd3, 1'b0);
    pulse_start();
    wait_done("timeout");
    check("timeout_req_cycles", 64'(req_cycles - base_req), 64'd1024);

`ifdef SECBOOT_ANTI_ROLLBACK_EN
    // Version 1 below fused minimum 2: rollback, image 0 fetched once.
    min_version = {32'd1, 32'd2};
    do_reset();
    mode = FM_HIGH;
    push_image_addrs(0);
    push_result(3'd7, 2'b00, 1'b0, 1'b1, 2'd2, 1'b0);
    pulse_start();
    wait_done("rollback");
    repeat (3) @(posedge clk);
    #1;
    check("rollback_addr_q_empty", 64'(exp_addr_q.size()), 64'd0);
`endif

    check("final_res_q_empty", 64'(exp_res_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
